// File: rtl/noc_pkg.sv
// Shared route encoding, per-channel FSM states and mesh sizing helper for
// the mesh router's routing logic.
package noc_pkg;

    typedef logic [2:0] route_t;

    localparam route_t ROUTE_LOCAL = 3'd0;
    localparam route_t ROUTE_NORTH = 3'd1;
    localparam route_t ROUTE_SOUTH = 3'd2;
    localparam route_t ROUTE_EAST  = 3'd3;
    localparam route_t ROUTE_WEST  = 3'd4;

    localparam int CNT_W = 16;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } ch_state_e;

    // Node ID width: {y,x} packed with the minimum bits for each dimension.
    function automatic int id_width(input int mesh_x, input int mesh_y);
        return $clog2(mesh_x) + $clog2(mesh_y);
    endfunction

endpackage

// File: rtl/routing_unit_lock_if.sv
// Flit-side inputs and locked-route outputs of routing_unit_lock.
// The pkt_cnt signal exists only when ROUTE_PKT_CNT_EN is defined.
interface routing_unit_lock_if #(
    parameter int NUM_CH = 5,
    parameter int ID_W   = 4
);
    logic [NUM_CH-1:0]      flit_valid;
    logic [NUM_CH-1:0]      flit_head;
    logic [NUM_CH-1:0]      flit_tail;
    logic [NUM_CH*ID_W-1:0] flit_dest;
    logic [NUM_CH-1:0]      flit_fire;
    logic [NUM_CH-1:0]      route_valid;
    logic [NUM_CH*3-1:0]    route;
    logic [NUM_CH-1:0]      dest_err;
`ifdef ROUTE_PKT_CNT_EN
    logic [NUM_CH*16-1:0]   pkt_cnt;
`endif

    modport master (
        output flit_valid, flit_head, flit_tail, flit_dest, flit_fire,
`ifdef ROUTE_PKT_CNT_EN
        input  pkt_cnt,
`endif
        input  route_valid, route, dest_err
    );

    modport slave (
        input  flit_valid, flit_head, flit_tail, flit_dest, flit_fire,
`ifdef ROUTE_PKT_CNT_EN
        output pkt_cnt,
`endif
        output route_valid, route, dest_err
    );
endinterface

// File: rtl/xy_route_calc.sv
// Combinational dimension-ordered (X then Y) output-port selection with an
// out-of-range destination flag.
module xy_route_calc
    import noc_pkg::*;
#(
    parameter int MESH_X   = 4,
    parameter int MESH_Y   = 4,
    parameter int ROUTER_X = 0,
    parameter int ROUTER_Y = 0,
    parameter int XW       = $clog2(MESH_X),
    parameter int YW       = $clog2(MESH_Y)
) (
    input  logic [XW-1:0] x_d,
    input  logic [YW-1:0] y_d,
    output route_t        route,
    output logic          range_err
);
    localparam logic [31:0] MX = 32'(MESH_X);
    localparam logic [31:0] MY = 32'(MESH_Y);
    localparam logic [31:0] RX = 32'(ROUTER_X);
    localparam logic [31:0] RY = 32'(ROUTER_Y);

    logic [31:0] x_ext_s;
    logic [31:0] y_ext_s;

    assign x_ext_s = 32'(x_d);
    assign y_ext_s = 32'(y_d);

    // Out-of-range IDs go local so the NI can drop them.
    always_comb begin
        range_err = (x_ext_s >= MX) || (y_ext_s >= MY);
        route     = ROUTE_LOCAL;
        if (range_err) begin
            route = ROUTE_LOCAL;
        end else if (x_ext_s > RX) begin
            route = ROUTE_EAST;
        end else if (x_ext_s < RX) begin
            route = ROUTE_WEST;
        end else if (y_ext_s < RY) begin
            route = ROUTE_NORTH;
        end else if (y_ext_s > RY) begin
            route = ROUTE_SOUTH;
        end else begin
            route = ROUTE_LOCAL;
        end
    end
endmodule

// File: rtl/routing_unit_lock.sv
// Registered XY routing unit: each input channel locks a route on its head
// flit until the tail is consumed. ROUTE_PKT_CNT_EN adds per-channel packet counters.
module routing_unit_lock
    import noc_pkg::*;
#(
    parameter int MESH_X   = 4,
    parameter int MESH_Y   = 4,
    parameter int ROUTER_X = 0,
    parameter int ROUTER_Y = 0,
    parameter int NUM_CH   = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    routing_unit_lock_if.slave bus
);
    localparam int XW   = $clog2(MESH_X);
    localparam int YW   = $clog2(MESH_Y);
    localparam int ID_W = id_width(MESH_X, MESH_Y);

    logic [NUM_CH-1:0]   route_valid_s;
    logic [NUM_CH*3-1:0] route_s;
    logic [NUM_CH-1:0]   dest_err_s;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ch_state_e state_r;
        ch_state_e state_s;
        logic      load_s;
        route_t    calc_route_s;
        logic      calc_err_s;
        route_t    route_r;
        logic      err_r;

        xy_route_calc #(
            .MESH_X  (MESH_X),
            .MESH_Y  (MESH_Y),
            .ROUTER_X(ROUTER_X),
            .ROUTER_Y(ROUTER_Y),
            .XW      (XW),
            .YW      (YW)
        ) u_calc (
            .x_d      (bus.flit_dest[i*ID_W +: XW]),
            .y_d      (bus.flit_dest[i*ID_W+XW +: YW]),
            .route    (calc_route_s),
            .range_err(calc_err_s)
        );

        // Next state: IDLE waits for a head, LOCKED waits for the tail to fire.
        always_comb begin
            state_s = state_r;
            load_s  = 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.flit_valid[i] && bus.flit_head[i]) begin
                        state_s = ST_LOCKED;
                        load_s  = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_LOCKED: begin
                    if (bus.flit_fire[i] && bus.flit_tail[i]) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_LOCKED;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end

        // State, locked route and sticky range error; route holds after release.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_r <= ST_IDLE;
                route_r <= ROUTE_LOCAL;
                err_r   <= 1'b0;
            end else begin
                state_r <= state_s;
                if (load_s) begin
                    route_r <= calc_route_s;
                    err_r   <= err_r | calc_err_s;
                end
            end
        end

`ifdef ROUTE_PKT_CNT_EN
        logic [CNT_W-1:0] cnt_r;

        // Counts packets accepted on this channel, wrapping naturally.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_r <= 16'd0;
            end else if (load_s) begin
                cnt_r <= cnt_r + 16'd1;
            end
        end

        assign bus.pkt_cnt[i*CNT_W +: CNT_W] = cnt_r;
`endif

        assign route_valid_s[i]  = (state_r == ST_LOCKED);
        assign route_s[i*3 +: 3] = route_r;
        assign dest_err_s[i]     = err_r;
    end

    assign bus.route_valid = route_valid_s;
    assign bus.route       = route_s;
    assign bus.dest_err    = dest_err_s;
endmodule

// File: tb/tb_routing_unit_lock.sv
// Directed bench for routing_unit_lock: a 4x4 instance at router (1,2) and a
// 3x4 instance for out-of-range destinations.
module tb_routing_unit_lock;
    import noc_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    routing_unit_lock_if #(.NUM_CH(5), .ID_W(4)) bus_a ();
    routing_unit_lock_if #(.NUM_CH(5), .ID_W(4)) bus_b ();

    routing_unit_lock #(
        .MESH_X(4), .MESH_Y(4), .ROUTER_X(1), .ROUTER_Y(2), .NUM_CH(5)
    ) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));

    routing_unit_lock #(
        .MESH_X(3), .MESH_Y(4), .ROUTER_X(1), .ROUTER_Y(2), .NUM_CH(5)
    ) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    int vec_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        logic [3:0] dest;
        logic [2:0] exp_route;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        bus_a.flit_valid = 5'b0;
        bus_a.flit_head  = 5'b0;
        bus_a.flit_tail  = 5'b0;
        bus_a.flit_fire  = 5'b0;
        bus_a.flit_dest  = 20'b0;
    endtask

    task automatic idle_b();
        bus_b.flit_valid = 5'b0;
        bus_b.flit_head  = 5'b0;
        bus_b.flit_tail  = 5'b0;
        bus_b.flit_fire  = 5'b0;
        bus_b.flit_dest  = 20'b0;
    endtask

    task automatic set_a(input int ch, input logic v, input logic h, input logic t,
                         input logic f, input logic [3:0] d);
        bus_a.flit_valid[ch]       = v;
        bus_a.flit_head[ch]        = h;
        bus_a.flit_tail[ch]        = t;
        bus_a.flit_fire[ch]        = f;
        bus_a.flit_dest[ch*4 +: 4] = d;
    endtask

    task automatic set_b0(input logic v, input logic h, input logic t,
                          input logic f, input logic [3:0] d);
        bus_b.flit_valid[0]  = v;
        bus_b.flit_head[0]   = h;
        bus_b.flit_tail[0]   = t;
        bus_b.flit_fire[0]   = f;
        bus_b.flit_dest[3:0] = d;
    endtask

    initial begin
        // dest {y,x}: 0=(0,0) west, 9=(2,1) local, 11=(2,3) east, 1=(0,1) north, 13=(3,1) south
        tbl[0] = '{dest: 4'd0,  exp_route: 3'd4};
        tbl[1] = '{dest: 4'd9,  exp_route: 3'd0};
        tbl[2] = '{dest: 4'd11, exp_route: 3'd3};
        tbl[3] = '{dest: 4'd1,  exp_route: 3'd1};
        tbl[4] = '{dest: 4'd13, exp_route: 3'd2};

        idle_a();
        idle_b();
        #1;
        check("rst_route_valid", 32'(bus_a.route_valid), 32'd0);
        check("rst_route", 32'(bus_a.route), 32'd0);
        check("rst_dest_err", 32'(bus_a.dest_err), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        for (int k = 0; k < 5; k++) begin
            set_a(0, 1'b1, 1'b1, 1'b0, 1'b0, tbl[k].dest);
            tick();
            check($sformatf("tbl%0d_valid", k), 32'(bus_a.route_valid[0]), 32'd1);
            check($sformatf("tbl%0d_route", k), 32'(bus_a.route[2:0]), 32'(tbl[k].exp_route));
            set_a(0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
            tick();
            check($sformatf("tbl%0d_release", k), 32'(bus_a.route_valid[0]), 32'd0);
            idle_a();
        end
`ifdef ROUTE_PKT_CNT_EN
        check("pkt_cnt_ch0", 32'(bus_a.pkt_cnt[15:0]), 32'd5);
`endif

        // Two channels routed in the same cycle.
        set_a(0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        set_a(4, 1'b1, 1'b1, 1'b0, 1'b0, 4'd11);
        tick();
        check("sim_valid", 32'(bus_a.route_valid), 32'h11);
        check("sim_route0", 32'(bus_a.route[2:0]), 32'd4);
        check("sim_route4", 32'(bus_a.route[14:12]), 32'd3);
        set_a(0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
        set_a(4, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
        tick();
        check("sim_release", 32'(bus_a.route_valid), 32'd0);
        idle_a();

        // 4-flit packet on ch2: body dest and a spurious head must not disturb the lock.
        set_a(2, 1'b1, 1'b1, 1'b0, 1'b0, 4'd11);
        tick();
        check("pkt4_head_valid", 32'(bus_a.route_valid[2]), 32'd1);
        check("pkt4_head_route", 32'(bus_a.route[8:6]), 32'd3);
        set_a(2, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        tick();
        check("pkt4_b1_route", 32'(bus_a.route[8:6]), 32'd3);
        set_a(2, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0);
        tick();
        check("pkt4_b2_valid", 32'(bus_a.route_valid[2]), 32'd1);
        check("pkt4_b2_route", 32'(bus_a.route[8:6]), 32'd3);
        set_a(2, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
        tick();
        check("pkt4_tail_valid", 32'(bus_a.route_valid[2]), 32'd0);
        check("pkt4_tail_route_held", 32'(bus_a.route[8:6]), 32'd3);
        idle_a();

        // Single-flit packet, next head waiting on the line: one bubble cycle.
        set_a(0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd9);
        tick();
        check("sf_valid", 32'(bus_a.route_valid[0]), 32'd1);
        check("sf_route", 32'(bus_a.route[2:0]), 32'd0);
        set_a(0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0);
        bus_a.flit_tail[0] = 1'b1;
        tick();
        check("sf_bubble", 32'(bus_a.route_valid[0]), 32'd0);
        set_a(0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        tick();
        check("sf_next_valid", 32'(bus_a.route_valid[0]), 32'd1);
        check("sf_next_route", 32'(bus_a.route[2:0]), 32'd4);
        set_a(0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
        tick();
        idle_a();

        // Orphan body/tail on ch3 is ignored; a later head still routes.
        set_a(3, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
        tick();
        tick();
        check("orphan_valid", 32'(bus_a.route_valid[3]), 32'd0);
        check("orphan_route", 32'(bus_a.route[11:9]), 32'd0);
        set_a(3, 1'b1, 1'b1, 1'b0, 1'b0, 4'd11);
        tick();
        check("orphan_then_head", 32'(bus_a.route[11:9]) | (32'(bus_a.route_valid[3]) << 3), 32'hB);
        set_a(3, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
        tick();
        idle_a();

        // 3-column mesh: x=3 is out of range, error stays set across packets.
        set_b0(1'b1, 1'b1, 1'b1, 1'b0, 4'd3);
        tick();
        check("rng_valid", 32'(bus_b.route_valid[0]), 32'd1);
        check("rng_route", 32'(bus_b.route[2:0]), 32'd0);
        check("rng_err", 32'(bus_b.dest_err), 32'd1);
        set_b0(1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
        tick();
        set_b0(1'b1, 1'b1, 1'b1, 1'b0, 4'd6);
        tick();
        check("rng_next_route", 32'(bus_b.route[2:0]), 32'd3);
        check("rng_err_sticky", 32'(bus_b.dest_err), 32'd1);
        check("rng_other_dut_err", 32'(bus_a.dest_err), 32'd0);
        set_b0(1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
        tick();
        idle_b();

        // Async reset while ch1 is locked.
        set_a(1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd11);
        tick();
        check("mid_locked", 32'(bus_a.route_valid[1]), 32'd1);
        idle_a();
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus_a.route_valid), 32'd0);
        check("mid_rst_route", 32'(bus_a.route), 32'd0);
        check("mid_rst_err_b", 32'(bus_b.dest_err), 32'd0);
`ifdef ROUTE_PKT_CNT_EN
        check("mid_rst_cnt", 32'(bus_a.pkt_cnt[31:16]), 32'd0);
`endif
        rst_n = 1'b1;
        #1;
        set_a(1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd13);
        tick();
        check("post_rst_valid", 32'(bus_a.route_valid[1]), 32'd1);
        check("post_rst_route", 32'(bus_a.route[5:3]), 32'd2);
`ifdef ROUTE_PKT_CNT_EN
        check("post_rst_cnt", 32'(bus_a.pkt_cnt[31:16]), 32'd1);
`endif
        idle_a();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/routing_unit_lock.md
Name: routing_unit_lock

Overview:
- Parametrised, registered successor to the combinational XY routing unit of the mesh router.
- Each input channel computes a dimension-ordered (XY) output port when a head flit arrives, registers it, and holds it until that packet's tail flit is consumed.
- Sits between the input buffers and the switch allocator of each router.
- Generalised to any MESH_X × MESH_Y mesh and any number of input channels; adds out-of-range destination detection.

Parameters:
- MESH_X, 4, mesh columns (≥2)
- MESH_Y, 4, mesh rows (≥2)
- ROUTER_X, 0, this router's column, 0..MESH_X-1
- ROUTER_Y, 0, this router's row, 0..MESH_Y-1
- NUM_CH, 5, input channels; index order is local, north, south, east, west, then extras
- Derived: XW=$clog2(MESH_X), YW=$clog2(MESH_Y), ID_W=XW+YW

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flit_valid  in  NUM_CH  flit present on channel i
- flit_head  in  NUM_CH  flit on channel i is a head
- flit_tail  in  NUM_CH  flit on channel i is a tail (head+tail = single-flit packet)
- flit_dest  in  NUM_CH*ID_W  destination {y,x}, channel i at [i*ID_W +: ID_W]
- flit_fire  in  NUM_CH  flit on channel i consumed downstream this cycle
- route_valid  out  NUM_CH  route for channel i is locked and valid
- route  out  NUM_CH*3  output port for channel i at [i*3 +: 3]
- dest_err  out  NUM_CH  sticky: out-of-range destination seen on channel i

Behaviour:
- Reset: async on rst_n=0. All route_valid=0, route=0, dest_err=0, every FSM in IDLE.
- Route encoding: 0 local, 1 north, 2 south, 3 east, 4 west; 5–7 never driven.
- XY rule: resolve x first.
  - x_d>ROUTER_X → east; x_d<ROUTER_X → west.
  - Else y_d<ROUTER_Y → north; y_d>ROUTER_Y → south.
  - Else local.
- Range check: if x_d≥MESH_X or y_d≥MESH_Y, route=local (drop at NI) and dest_err[i] sets. dest_err clears only on reset.
- Per-channel FSM, IDLE state:
  - flit_valid & flit_head → load route register, go to LOCKED. route_valid rises the next cycle (1-cycle latency).
  - flit_valid without head (orphan body/tail) → ignored, stay IDLE, no output change.
- Per-channel FSM, LOCKED state:
  - route and route_valid=1 held constant. flit_dest and flit_head are ignored.
  - flit_fire & flit_tail → IDLE. route_valid falls the next cycle; route keeps its last value.
  - flit_fire without tail → stay LOCKED.
- flit_fire while IDLE → ignored.
- A single-flit packet takes one cycle in LOCKED minimum: head seen in cycle N, route_valid in N+1, fire in N+1 releases, route_valid=0 in N+2.
- Back-to-back packets: the next head is sampled no earlier than the cycle after the tail fire, giving one mandatory bubble per packet.
- Channels are fully independent; any combination of simultaneous events across channels is legal.
- Reset asserted mid-packet → immediate return to IDLE with outputs cleared. The partial packet is forgotten.

Optional Feature:
- Macro: ROUTE_PKT_CNT_EN
- Defined:
  - Adds output pkt_cnt, NUM_CH*16 bits.
  - Per-channel counter increments on each IDLE→LOCKED transition and wraps 0xFFFF→0.
  - Reset to 0.
- Undefined: port and counters absent; all other behaviour identical.

Decomposition:
- Package noc_pkg holds:
  - Route encoding constants ROUTE_LOCAL/NORTH/SOUTH/EAST/WEST (3-bit).
  - Typedef route_t.
  - Helper for ID width from mesh dimensions.
- One sub-module xy_route_calc: combinational, inputs x_d, y_d, ROUTER_X/Y and mesh params; outputs route_t and range-error flag. Instantiated NUM_CH times in a generate loop.
- The per-channel FSM stays in the top.

Test Plan (defaults, ROUTER_X=1, ROUTER_Y=2, so router ID = 4'b1001):
- Head with dest 0, 9, 11, 1, 13 on channel 0 → route 4 (west), 0 (local), 3 (east), 1 (north), 2 (south), each with route_valid=1 one cycle after the head.
- 4-flit packet, dest 11 on channel 2; flit_dest changes to 0 on body flits → route stays 3 until tail fire, then route_valid=0 the next cycle.
- Single-flit packet (head+tail) fired the cycle route_valid rises, followed immediately by a new head with dest 0 → one bubble, then route=4.
- Body flit with flit_valid=1, head=0 while IDLE on channel 3 → no route_valid, state stays IDLE.
- Instance MESH_X=3: dest x=3 → route=0 and dest_err[i]=1, sticky across later packets until rst_n pulse.
- rst_n low for 1 cycle while channel 1 is LOCKED → route_valid=0 asynchronously; the next head is routed normally; with ROUTE_PKT_CNT_EN, pkt_cnt=0 after reset and 1 after that head.
